// File: rtl/imm_extend_stage.sv
// Immediate extension stage: zero/sign/upper/branch extension into a 2-entry skid buffer.
// Latency: 1 cycle from accepted input to out_valid when the buffer is empty.
// Backpressure: in_ready is registered and drops only when both entries are held (TWO).
//
// Extension is computed when a word is accepted, and the stored result is held.
// out_data is driven straight from the main register. The skid register absorbs
// the one extra word that can arrive while the consumer stalls. Because in_ready
// is a flop, the producer never sees a combinational path from out_ready.
// OUT_W must be at least IN_W+2 so the branch mode keeps all input bits after
// the left shift by 2.

module imm_extend_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int PAD_W = OUT_W - IN_W;

    // Extension mode encodings
    localparam logic [1:0] MODE_ZERO   = 2'b00;
    localparam logic [1:0] MODE_SIGN   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] main_q, main_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] ext_dat;
    logic             acc;
    logic             xfer;

    // Handshakes. A word offered while in_ready is low is simply not taken.
    assign acc  = in_valid & in_ready_q;
    assign xfer = out_valid_q & out_ready;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    // Extend the incoming immediate according to in_mode.
    always_comb begin
        ext_dat = {{PAD_W{1'b0}}, in_data};
        case (in_mode)
            MODE_ZERO:   ext_dat = {{PAD_W{1'b0}}, in_data};
            MODE_SIGN:   ext_dat = {{PAD_W{in_data[IN_W-1]}}, in_data};
            MODE_UPPER:  ext_dat = {in_data, {PAD_W{1'b0}}};
            // Sign-extend, then shift left by 2. The two top sign copies fall off.
            MODE_BRANCH: ext_dat = {{(PAD_W-2){in_data[IN_W-1]}}, in_data, 2'b00};
            default:     ext_dat = {{PAD_W{1'b0}}, in_data};
        endcase
    end

    // Next state and data movement for the skid buffer.
    // flush overrides every transfer. The registers keep their contents, so
    // out_data still shows its last value once out_valid is low.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d = ST_ONE;
                        main_d  = ext_dat;
                    end
                end
                ST_ONE: begin
                    if (acc && !xfer) begin
                        // Consumer is stalled, so park the new word behind main.
                        state_d = ST_TWO;
                        skid_d  = ext_dat;
                    end else if (acc && xfer) begin
                        main_d  = ext_dat;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Nothing is accepted here. Draining main promotes skid.
                    if (xfer) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and storage registers. The handshake flags are registered copies
    // decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage with a queue scoreboard.
// Expected words are pushed when the bench samples an accepted input.
// They are popped and compared whenever an output transfer is sampled.

module tb_imm_extend_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    // Narrow instance for the parameter check
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_data8;
    logic [1:0]  in_mode8;
    logic        flush8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] out_data8;

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_out   = 0;
    logic        last_acc;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    imm_extend_stage #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    imm_extend_stage #(.IN_W(8), .OUT_W(16)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .in_mode   (in_mode8),
        .flush     (flush8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8)
    );

    // Reference extension for the 16->32 instance
    function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
        logic [31:0] s;
        s = d[15] ? (32'hFFFF_0000 | {16'h0000, d}) : {16'h0000, d};
        case (m)
            2'd0:    model = {16'h0000, d};
            2'd1:    model = s;
            2'd2:    model = {d, 16'h0000};
            default: model = s * 32'd4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock. Handshakes are sampled at the falling edge, then the bench
    // returns 1 time unit after the rising edge so the caller can drive inputs.
    task automatic cyc();
        @(negedge clk);
        last_acc = in_valid && in_ready && !flush;
        if (out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0)
                chk("unexpected_output", out_data, 32'hxxxx_xxxx);
            else
                chk("out_data", out_data, sb_q.pop_front());
        end
        if (flush)
            sb_q.delete();
        else if (in_valid && in_ready)
            sb_q.push_back(model(in_data, in_mode));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc();
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        logic [15:0] sweep_d;
        logic [31:0] stall_dat;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0;
        flush = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; in_mode8 = '0; flush8 = 1'b0; out_ready8 = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_data",  out_data,           32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Mode sweep: each result must appear exactly one cycle after acceptance
        sweep_d = 16'h8001;
        for (int m = 0; m < 4; m++) begin
            in_valid = 1'b1; in_data = sweep_d; in_mode = 2'(m);
            cyc();
            in_valid = 1'b0;
            chk("sweep_valid", {31'd0, out_valid}, 32'd1);
            case (m)
                0:       chk("sweep_m00", out_data, 32'h0000_8001);
                1:       chk("sweep_m01", out_data, 32'hFFFF_8001);
                2:       chk("sweep_m10", out_data, 32'h8001_0000);
                default: chk("sweep_m11", out_data, 32'hFFFE_0004);
            endcase
            cyc();
            chk("sweep_empty", {31'd0, out_valid}, 32'd0);
        end

        // Back-pressure: A and B are taken, C waits, and out_data holds during the stall
        out_ready = 1'b0; in_mode = 2'b00; n0 = n_out;
        in_valid = 1'b1; in_data = 16'h0001; cyc();
        in_data = 16'h0002; cyc();
        in_data = 16'h0003;
        chk("bp_in_ready_two", {31'd0, in_ready}, 32'd0);
        stall_dat = out_data;
        chk("bp_head", stall_dat, 32'h1);
        cyc();
        chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_stable1", out_data, stall_dat);
        cyc();
        chk("bp_stable2", out_data, stall_dat);
        chk("bp_c_not_taken", {31'd0, last_acc}, 32'd0);
        out_ready = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 10 && !last_acc; i++) cyc();
        chk("bp_c_accepted", {31'd0, last_acc}, 32'd1);
        in_valid = 1'b0;
        drain();
        chk("bp_out_count", 32'(n_out - n0), 32'd3);

        // Full throughput: 8 back-to-back words with the consumer always ready
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            in_mode  = 2'($urandom_range(3));
            if (i > 0) chk("tp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("tp_in_ready", {31'd0, in_ready}, 32'd1);
            cyc();
        end
        in_valid = 1'b0;
        chk("tp_last_valid", {31'd0, out_valid}, 32'd1);
        cyc();
        chk("tp_out_count", 32'(n_out - n0), 32'd8);
        chk("tp_sb_empty", 32'(sb_q.size()), 32'd0);

        // Flush in TWO with a new word offered in the same cycle
        out_ready = 1'b0; in_mode = 2'b00;
        in_valid = 1'b1; in_data = 16'h1111; cyc();
        in_data = 16'h2222; cyc();
        chk("fl2_in_two", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; in_data = 16'hBEEF; cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl2_in_ready",  {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fl2_no_word", {31'd0, out_valid}, 32'd0);
        end

        // Flush in ONE: the input offered with flush is discarded even though in_ready=1
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h3333; cyc();
        flush = 1'b1; in_data = 16'h4444;
        chk("fl1_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl1_out_valid", {31'd0, out_valid}, 32'd0);
        cyc();
        chk("fl1_no_word", {31'd0, out_valid}, 32'd0);

        // Async reset mid-cycle while holding one word
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h5555; cyc();
        in_valid = 1'b0;
        chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_in_ready",  {31'd0, in_ready},  32'd1);
        chk("ar_out_data",  out_data,           32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'hFFFF; in_mode = 2'b11;
        cyc();
        in_valid = 1'b0;
        chk("ar_post_valid", {31'd0, out_valid}, 32'd1);
        chk("ar_post_data",  out_data,           32'hFFFF_FFFC);
        cyc();
        chk("ar_post_empty", {31'd0, out_valid}, 32'd0);

        // Narrow instance: IN_W=8, OUT_W=16
        chk("p8_in_ready", {31'd0, in_ready8}, 32'd1);
        in_valid8 = 1'b1; in_data8 = 8'h80; in_mode8 = 2'b01;
        @(posedge clk); #1;
        in_mode8 = 2'b11;
        chk("p8_valid", {31'd0, out_valid8}, 32'd1);
        chk("p8_sign",  {16'd0, out_data8},  32'h0000_FF80);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk("p8_branch", {16'd0, out_data8}, 32'h0000_FE00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imm_extend_stage.md
IMM_EXTEND_STAGE -- requirements
Module: imm_extend_stage

Interface
REQ-001 Parameter IN_W, default 16, immediate input width.
REQ-002 Parameter OUT_W, default 32, extended output width; legal only when OUT_W >= IN_W+2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer presents in_data/in_mode this cycle.
REQ-006 in_ready  output  1  block accepts a word this cycle; registered, not combinational from out_ready.
REQ-007 in_data  input  IN_W  raw immediate field.
REQ-008 in_mode  input  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
REQ-009 flush  input  1  synchronous discard of all held words, e.g. on branch mispredict.
REQ-010 out_valid  output  1  out_data holds a valid extended word.
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 out_data  output  OUT_W  extended immediate.

Function
REQ-013 Input transfer occurs when in_valid and in_ready are both 1; output transfer occurs when out_valid and out_ready are both 1.
REQ-014 Mode 00 SHALL produce IN_W input bits zero-padded to OUT_W.
REQ-015 Mode 01 SHALL produce in_data[IN_W-1] replicated into the upper OUT_W-IN_W bits.
REQ-016 Mode 10 SHALL produce in_data in bits [OUT_W-1:OUT_W-IN_W] with zeros below.
REQ-017 Mode 11 SHALL produce the mode-01 result shifted left by 2, truncated to OUT_W bits, with zeros in bits [1:0].
REQ-018 Extension SHALL be computed at acceptance and stored; latency from accepted input to out_valid SHALL be exactly 1 cycle when the block is empty.
REQ-019 Storage SHALL be a 2-entry skid buffer (main register drives out_data, plus a skid register), with states EMPTY, ONE and TWO.
REQ-020 EMPTY: an accepted input goes to ONE.
REQ-021 ONE: accept with no output transfer goes to TWO, with the new word in skid; accept with transfer stays in ONE, with the new word in main; transfer without accept goes to EMPTY.
REQ-022 TWO: an output transfer moves skid to main and goes to ONE; no input is accepted in TWO.
REQ-023 in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO.
REQ-024 out_valid SHALL be 1 in ONE and TWO; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Words SHALL leave in acceptance order; none SHALL be dropped or duplicated outside flush.
REQ-026 flush=1 SHALL force EMPTY at the next edge, dominating any simultaneous input or output transfer.
REQ-027 An input presented in the same cycle as flush SHALL be discarded.
REQ-028 The output transfer in a flush cycle SHALL still count as completed for the consumer.
REQ-029 When out_valid=0, out_data SHALL hold its last value; it is not required to be zero.

Reset
REQ-030 While rst_n=0, the state SHALL be EMPTY, out_valid=0, in_ready=1, out_data=0 and the skid register=0, all asynchronously.
REQ-031 Deassertion of rst_n SHALL take effect at the first rising clk edge after it; reset mid-transfer SHALL lose all held words with no partial output.

Verification
REQ-032 Mode sweep, out_ready=1, in_data=0x8001: mode 00 -> 0x00008001, mode 01 -> 0xFFFF8001, mode 10 -> 0x80010000, mode 11 -> 0xFFFE0004, each one cycle after acceptance.
REQ-033 Back-pressure: out_ready=0, offer A=0x0001, B=0x0002, C=0x0003 in mode 00 -> A and B accepted, in_ready=0 while C is held; release out_ready -> output 0x1, 0x2, 0x3 in order, out_data stable during the stall.
REQ-034 Full throughput: continuous in_valid and out_ready=1 for 8 words -> one output per cycle, in_ready constantly 1.
REQ-035 Flush in TWO with flush and a new in_valid in the same cycle -> next cycle out_valid=0, in_ready=1, the new word never appears.
REQ-036 Async reset asserted mid-cycle in ONE -> out_valid=0 immediately, before the next edge; the first post-reset input 0xFFFF in mode 11 -> 0xFFFFFFFC.
REQ-037 Parameter check IN_W=8, OUT_W=16, in_data=0x80, mode 01 -> 0xFF80.
